// File: rtl/ls_writeback_buffer.sv
// Completion buffer between LSU writeback and the writeback arbiter. Loads reserve a slot at issue so
// completions never stall; results drain in arrival order through a registered valid/ack output.
module ls_writeback_buffer #(
  parameter int DEPTH  = 4,
  parameter int DATA_W = 32,
  parameter int ID_W   = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              reserve,
  output logic              space_available,
  input  logic              in_done,
  input  logic [ID_W-1:0]   in_id,
  input  logic [DATA_W-1:0] in_rd,
  input  logic              csr_bypass,
  output logic              out_valid,
  output logic [ID_W-1:0]   out_id,
  output logic [DATA_W-1:0] out_rd,
  input  logic              out_ack,
  output logic              empty,
  output logic              error
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

  logic [ID_W+DATA_W-1:0] mem_q [DEPTH];

  logic [CW-1:0]     count_q, count_d;
  logic [CW-1:0]     reserved_q, reserved_d;
  logic [PW-1:0]     rd_ptr_q, rd_ptr_d;
  logic [PW-1:0]     wr_ptr_q, wr_ptr_d;
  logic              out_valid_q, out_valid_d;
  logic [ID_W-1:0]   out_id_q, out_id_d;
  logic [DATA_W-1:0] out_rd_q, out_rd_d;
  logic              error_q, error_d;

  logic          pop, push, full, res_ok, consume, no_res;
  logic [PW-1:0] head_ptr;

  assign space_available = (count_q + reserved_q) < DEPTH_C;
  assign empty           = (count_q == '0) && (reserved_q == '0);
  assign out_valid       = out_valid_q;
  assign out_id          = out_id_q;
  assign out_rd          = out_rd_q;
  assign error           = error_q;

  always_comb begin
    pop      = out_valid_q & out_ack;
    full     = (count_q == DEPTH_C);
    // At full, a completion is still accepted if the head leaves in the same cycle.
    push     = in_done & (~full | pop);
    res_ok   = reserve & space_available;
    no_res   = (reserved_q == '0);
    consume  = in_done & ~csr_bypass & ~no_res;
    head_ptr = rd_ptr_q + PW'(pop);

    count_d    = count_q + CW'(push) - CW'(pop);
    reserved_d = reserved_q + CW'(res_ok) - CW'(consume);
    rd_ptr_d   = head_ptr;
    wr_ptr_d   = wr_ptr_q + PW'(push);

    // The output stage only sees entries stored before this edge, giving one cycle of latency.
    out_valid_d = (count_q - CW'(pop)) != '0;
    out_id_d    = out_id_q;
    out_rd_d    = out_rd_q;
    if (out_valid_d) begin
      {out_id_d, out_rd_d} = mem_q[head_ptr];
    end

    error_d = error_q
            | (reserve & ~space_available)
            | (in_done & full & ~pop)
            | (in_done & ~csr_bypass & no_res);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q     <= '0;
      reserved_q  <= '0;
      rd_ptr_q    <= '0;
      wr_ptr_q    <= '0;
      out_valid_q <= 1'b0;
      out_id_q    <= '0;
      out_rd_q    <= '0;
      error_q     <= 1'b0;
    end else begin
      count_q     <= count_d;
      reserved_q  <= reserved_d;
      rd_ptr_q    <= rd_ptr_d;
      wr_ptr_q    <= wr_ptr_d;
      out_valid_q <= out_valid_d;
      out_id_q    <= out_id_d;
      out_rd_q    <= out_rd_d;
      error_q     <= error_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_ptr_q] <= {in_id, in_rd};
    end
  end
endmodule

// File: tb/tb_ls_writeback_buffer.sv
// Randomized and directed checks of ls_writeback_buffer against a queue-based reference model.
module tb_ls_writeback_buffer;
  localparam int DEPTH = 4, DATA_W = 32, ID_W = 3;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst, reserve, in_done, csr_bypass, out_ack;
  logic [ID_W-1:0] in_id;
  logic [DATA_W-1:0] in_rd;
  logic space_available, out_valid, empty, error;
  logic [ID_W-1:0] out_id;
  logic [DATA_W-1:0] out_rd;

  ls_writeback_buffer #(.DEPTH(DEPTH), .DATA_W(DATA_W), .ID_W(ID_W)) dut (
    .clk(clk), .rst(rst), .reserve(reserve), .space_available(space_available),
    .in_done(in_done), .in_id(in_id), .in_rd(in_rd), .csr_bypass(csr_bypass),
    .out_valid(out_valid), .out_id(out_id), .out_rd(out_rd), .out_ack(out_ack),
    .empty(empty), .error(error)
  );

  typedef struct packed {
    logic [ID_W-1:0]   id;
    logic [DATA_W-1:0] rd;
  } ent_t;

  int checks = 0, errors = 0;
  ent_t m_q[$];
  int   m_res;
  bit   m_err, m_valid;
  ent_t m_out;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h @%0t", tag, got, exp, $time);
    end
  endtask

  task automatic compare_all();
    check("out_valid", 64'(out_valid), 64'(m_valid));
    if (m_valid) begin
      check("out_id", 64'(out_id), 64'(m_out.id));
      check("out_rd", 64'(out_rd), 64'(m_out.rd));
    end
    check("space_available", 64'(space_available), 64'((m_q.size() + m_res) < DEPTH));
    check("empty", 64'(empty), 64'(m_q.size() == 0 && m_res == 0));
    check("error", 64'(error), 64'(m_err));
  endtask

  // One clock cycle: model update from pre-edge state, then compare after the edge.
  task automatic step(input bit r, input bit d, input logic [ID_W-1:0] id,
                      input logic [DATA_W-1:0] rd, input bit byp, input bit ack);
    bit pop, space, err_n, valid_n;
    int res_n, avail;
    ent_t e;
    reserve = r; in_done = d; in_id = id; in_rd = rd; csr_bypass = byp; out_ack = ack;
    pop   = m_valid && ack;
    space = (m_q.size() + m_res) < DEPTH;
    err_n = m_err;
    res_n = m_res;
    if (r) begin
      if (space) res_n++;
      else err_n = 1'b1;
    end
    if (d && !byp) begin
      if (m_res == 0) err_n = 1'b1;
      else res_n--;
    end
    avail   = m_q.size() - int'(pop);
    valid_n = avail > 0;
    if (valid_n) m_out = m_q[pop ? 1 : 0];
    if (pop) begin
      $display("pop  id=%0d rd=%08h", m_q[0].id, m_q[0].rd);
      void'(m_q.pop_front());
    end
    if (d) begin
      e.id = id; e.rd = rd;
      if (m_q.size() < DEPTH) m_q.push_back(e);
      else err_n = 1'b1;
    end
    m_res = res_n; m_err = err_n; m_valid = valid_n;
    @(posedge clk);
    #1;
    reserve = 0; in_done = 0; csr_bypass = 0; out_ack = 0;
    compare_all();
  endtask

  task automatic model_clear();
    m_q.delete(); m_res = 0; m_err = 1'b0; m_valid = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    #1;
    model_clear();
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_out_id", 64'(out_id), 64'd0);
    check("rst_out_rd", 64'(out_rd), 64'd0);
    check("rst_empty", 64'(empty), 64'd1);
    check("rst_space", 64'(space_available), 64'd1);
    check("rst_error", 64'(error), 64'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  initial begin
    reserve = 0; in_done = 0; csr_bypass = 0; out_ack = 0; in_id = '0; in_rd = '0;
    do_reset();

    // 1: single load, minimum latency, one-cycle output with ack held.
    step(1, 0, 0, 0, 0, 1);
    step(0, 0, 0, 0, 0, 1);
    step(0, 0, 0, 0, 0, 1);
    step(0, 1, 3'd2, 32'hDEAD_BEEF, 0, 1);
    check("t1_valid_c3", 64'(out_valid), 64'd0);
    step(0, 0, 0, 0, 0, 1);
    check("t1_valid_c4", 64'(out_valid), 64'd1);
    check("t1_id_c4", 64'(out_id), 64'd2);
    check("t1_rd_c4", 64'(out_rd), 64'hDEAD_BEEF);
    step(0, 0, 0, 0, 0, 1);
    check("t1_valid_c5", 64'(out_valid), 64'd0);
    check("t1_empty_c5", 64'(empty), 64'd1);

    // 2: reservations exhaust space; the extra reserve flags an error.
    do_reset();
    for (int i = 0; i < 4; i++) step(1, 0, 0, 0, 0, 0);
    check("t2_space", 64'(space_available), 64'd0);
    step(1, 0, 0, 0, 0, 0);
    check("t2_error", 64'(error), 64'd1);
    check("t2_empty", 64'(empty), 64'd0);

    // 3: fill, hold without ack, then drain in order.
    do_reset();
    for (int i = 0; i < 4; i++) step(1, 0, 0, 0, 0, 0);
    for (int i = 0; i < 4; i++) step(0, 1, 3'(i), 32'h100 + 32'(i), 0, 0);
    for (int i = 0; i < 3; i++) step(0, 0, 0, 0, 0, 0);
    check("t3_hold_id", 64'(out_id), 64'd0);
    for (int i = 0; i < 4; i++) begin
      check("t3_order", 64'(out_id), 64'(i));
      step(0, 0, 0, 0, 0, 1);
    end
    check("t3_empty", 64'(empty), 64'd1);

    // 4: push into a full buffer while the head is acked.
    do_reset();
    for (int i = 0; i < 4; i++) step(1, 0, 0, 0, 0, 0);
    for (int i = 0; i < 4; i++) step(0, 1, 3'(i), 32'h200 + 32'(i), 0, 0);
    step(0, 0, 0, 0, 0, 0);
    step(0, 1, 3'd5, 32'h5555, 1, 1);
    check("t4_no_error", 64'(error), 64'd0);
    check("t4_head", 64'(out_id), 64'd1);
    for (int i = 0; i < 3; i++) step(0, 0, 0, 0, 0, 1);
    check("t4_fourth", 64'(out_id), 64'd5);
    step(0, 0, 0, 0, 0, 1);

    // 5: CSR bypass completion while idle.
    do_reset();
    step(0, 1, 3'd7, 32'h1234, 1, 0);
    step(0, 0, 0, 0, 0, 0);
    check("t5_id", 64'(out_id), 64'd7);
    check("t5_rd", 64'(out_rd), 64'h1234);
    check("t5_error", 64'(error), 64'd0);
    step(0, 0, 0, 0, 0, 1);
    check("t5_empty", 64'(empty), 64'd1);

    // 6: asynchronous reset mid-operation.
    for (int i = 0; i < 4; i++) step(1, 0, 0, 0, 0, 0);
    for (int i = 0; i < 3; i++) step(0, 1, 3'(i), 32'h300 + 32'(i), 0, 0);
    #2;
    rst = 1'b1;
    #1;
    check("t6_valid", 64'(out_valid), 64'd0);
    check("t6_empty", 64'(empty), 64'd1);
    check("t6_space", 64'(space_available), 64'd1);
    model_clear();
    @(posedge clk);
    #1;
    rst = 1'b0;
    step(1, 0, 0, 0, 0, 0);
    step(0, 1, 3'd4, 32'h4444, 0, 0);
    step(0, 0, 0, 0, 0, 0);
    check("t6_first", 64'(out_id), 64'd4);

    // Randomized legal traffic against the model.
    do_reset();
    for (int n = 0; n < 500; n++) begin
      bit r, d, byp, ack;
      r = ($urandom % 3 == 0) && ((m_q.size() + m_res) < DEPTH);
      d = 1'b0; byp = 1'b0;
      if (m_res > 0 && ($urandom % 2 == 1)) d = 1'b1;
      else if (m_q.size() == 0 && m_res == 0 && ($urandom % 6 == 0)) begin
        d = 1'b1; byp = 1'b1;
      end
      ack = ($urandom % 3 != 0);
      step(r, d, 3'($urandom), $urandom, byp, ack);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
